// File: rtl/cpu_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
//   arb_state_t : arbiter sequencing states (IDLE -> ISSUE -> WAIT -> IDLE)
//   owner_t     : which requester owns the transaction in flight
//   FETCH_RMASK : all-ones read mask used for instruction fetches. Users slice
//                 the low DW/8 bits, so data widths up to 512 bits are covered.
package cpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int unsigned MASK_W_MAX = 64;
  localparam logic [MASK_W_MAX-1:0] FETCH_RMASK = '1;

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog for the memory wait phase.
// The timer is cleared whenever run_i is low. While run_i is high it counts up
// and saturates at TIMEOUT. expired_o is high when the timer has reached
// TIMEOUT during a run. When a run expires without ready_i, err_o is set and
// stays set until rst.
// Ports:
//   clk, rst   : clock; synchronous active-high reset
//   run_i      : arbiter is waiting for the memory
//   ready_i    : memory completion in this cycle
//   expired_o  : wait budget used up in this cycle
//   err_o      : sticky timeout flag
module mem_arb_wdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic ready_i,
  output logic expired_o,
  output logic err_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  assign expired_o = run_i && (timer_q == TMAX);

  always_comb begin
    timer_d = timer_q;
    if (!run_i) begin
      timer_d = '0;
    end else if (timer_q != TMAX) begin
      timer_d = timer_q + 1'b1;
    end
    // If ready arrives in the same cycle as expiry, the transfer completes normally.
    err_d = err_q | (expired_o & ~ready_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Lets instruction fetch (IF) and data load/store (DM) share one single-port
// memory. The arbiter runs one transaction at a time, and DM has priority
// over IF.
//
// Optional feature: define ARB_STARVE_GUARD_EN to enable the starvation
// guard. It counts consecutive DM grants made while if_req is high. When the
// count reaches STARVE_LIMIT, the next grant goes to IF. Any IF grant clears
// the count. A DM grant made while if_req is low also clears the count.
//
// Ports:
//   clk, rst                 : clock; synchronous active-high reset
//   if_req/if_addr           : fetch request (held until if_ack) and address
//   if_rdata/if_ack          : fetched word, valid with the one-cycle ack
//   dm_req/dm_we/dm_addr     : data request, store flag, address
//   dm_wdata/dm_wmask/rmask  : store data, byte write mask, byte read mask
//   dm_rdata/dm_ack          : load data (0 for stores), valid with the ack
//   mem_ce                   : one-cycle command strobe per transaction
//   mem_we/addr/wdata/wmask/rmask : registered command, held until the next grant
//   mem_rdata/mem_ready      : memory response; ready is ignored in the ISSUE cycle
//   stall                    : a request is high and its ack is not in this cycle
//   err                      : sticky timeout flag, cleared only by rst
//
// Handshake: a requester holds req until the cycle of its ack. Requests are
// sampled only in IDLE, and not in an ack cycle. The ack is a single-cycle
// pulse. The matching rdata output stays valid until the next ack for that
// requester.
module unified_mem_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
`ifdef ARB_STARVE_GUARD_EN
  , parameter int unsigned STARVE_LIMIT = 4
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_wmask,
  input  logic [DW/8-1:0] dm_rmask,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_ack,
  output logic            mem_ce,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  output logic [DW/8-1:0] mem_rmask,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready,
  output logic            stall,
  output logic            err
);

  localparam int unsigned MW = DW / 8;

  arb_state_t      state_q;
  owner_t          owner_q;
  logic            cmd_ce_q, cmd_we_q;
  logic [AW-1:0]   cmd_addr_q;
  logic [DW-1:0]   cmd_wdata_q;
  logic [MW-1:0]   cmd_wmask_q, cmd_rmask_q;
  logic            if_ack_q, dm_ack_q;
  logic [DW-1:0]   if_rdata_q, dm_rdata_q;
  logic            wd_expired, wd_err;
  logic            ack_busy, done, grant_dm;
  logic [DW-1:0]   resp_data;

  assign ack_busy  = if_ack_q | dm_ack_q;
  assign done      = (state_q == WAIT) && (mem_ready || wd_expired);
  // A timed-out transfer returns zero to its owner.
  assign resp_data = mem_ready ? mem_rdata : '0;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_q;
  assign grant_dm = dm_req && !(if_req && (starve_q == STARVE_MAX));
`else
  assign grant_dm = dm_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      cmd_ce_q    <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wmask_q <= '0;
      cmd_rmask_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q    <= '0;
`endif
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // A requester is still holding req in its own ack cycle, so that cycle is skipped.
          if (!ack_busy && (if_req || dm_req)) begin
            state_q  <= ISSUE;
            cmd_ce_q <= 1'b1;
            if (grant_dm) begin
              owner_q     <= OWN_DM;
              cmd_we_q    <= dm_we;
              cmd_addr_q  <= dm_addr;
              cmd_wdata_q <= dm_wdata;
              cmd_wmask_q <= dm_wmask;
              cmd_rmask_q <= dm_rmask;
            end else begin
              owner_q     <= OWN_IF;
              cmd_we_q    <= 1'b0;
              cmd_addr_q  <= if_addr;
              cmd_wdata_q <= '0;
              cmd_wmask_q <= '0;
              cmd_rmask_q <= FETCH_RMASK[MW-1:0];
            end
`ifdef ARB_STARVE_GUARD_EN
            if (grant_dm && if_req) starve_q <= starve_q + 1'b1;
            else                    starve_q <= '0;
`endif
          end
        end
        ISSUE: begin
          cmd_ce_q <= 1'b0;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (done) begin
            state_q <= IDLE;
            if (owner_q == OWN_DM) begin
              dm_ack_q   <= 1'b1;
              dm_rdata_q <= cmd_we_q ? '0 : resp_data;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= resp_data;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .run_i     (state_q == WAIT),
    .ready_i   (mem_ready),
    .expired_o (wd_expired),
    .err_o     (wd_err)
  );

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_ce    = cmd_ce_q;
  assign mem_we    = cmd_we_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_wdata = cmd_wdata_q;
  assign mem_wmask = cmd_wmask_q;
  assign mem_rmask = cmd_rmask_q;
  assign stall     = (if_req & ~if_ack_q) | (dm_req & ~dm_ack_q);
  assign err       = wd_err;

endmodule
